// File: rtl/bp_be_stride_pf_gen_if.sv
// bp_be_stride_pf_gen_if: RPT trigger/discovery inputs, prefetch valid/ready/addr bus, busy and drop status
interface bp_be_stride_pf_gen_if #(
   parameter int vaddr_width_p  = 39,
   parameter int stride_width_p = 8
);
   logic                      stride_v;
   logic [stride_width_p-1:0] stride;
   logic [vaddr_width_p-1:0]  pc;
   logic [vaddr_width_p-1:0]  base_addr;
   logic                      start_discovery;
   logic                      confirm_discovery;
   logic                      pf_v;
   logic [vaddr_width_p-1:0]  pf_addr;
   logic                      pf_ready;
   logic                      busy;
   logic [7:0]                drop_cnt;
   modport master (
      output stride_v, stride, pc, base_addr, start_discovery, confirm_discovery, pf_ready,
      input  pf_v, pf_addr, busy, drop_cnt
   );
   modport slave (
      input  stride_v, stride, pc, base_addr, start_discovery, confirm_discovery, pf_ready,
      output pf_v, pf_addr, busy, drop_cnt
   );
endinterface

// File: rtl/bp_be_stride_pf_gen.sv
// bp_be_stride_pf_gen: stride prefetch burst generator; ports clk_i, reset_i, bus (slave: stride trigger + discovery in, pf_v/pf_addr out with pf_ready in, busy/drop_cnt out)
module bp_be_stride_pf_gen #(
   parameter int vaddr_width_p        = 39,
   parameter int stride_width_p       = 8,
   parameter int degree_p             = 4,
   parameter int degree_unconfirmed_p = 1,
   parameter int block_offset_width_p = 6,
   parameter int page_offset_width_p  = 12
) (
   input logic                 clk_i,
   input logic                 reset_i,
   bp_be_stride_pf_gen_if.slave bus
);
   localparam logic [0:0] e_idle = 1'b0, e_issue = 1'b1;
   localparam int rem_w = $clog2(degree_p + 1);
   localparam int blk_w = vaddr_width_p - block_offset_width_p;
   localparam int pg_w  = vaddr_width_p - page_offset_width_p;
   logic [0:0]               state_r;
   logic                     confirmed_r, last_blk_v_r, skid_v_r;
   logic [vaddr_width_p-1:0] pc_r, stride_r, cand_r, skid_base_r, skid_stride_r;
   logic [pg_w-1:0]          base_pg_r;
   logic [blk_w-1:0]         last_blk_r, blk;
   logic [rem_w-1:0]         remaining_r, skid_rem_r, degree, ld_rem;
   logic [7:0]               drop_cnt_r;
   logic [vaddr_width_p-1:0] stride_sext, ld_base, ld_stride;
   logic                     trig, same_pc, page_cross, dup, pf_v, accept, restart_ok;
   logic                     restart, to_skid, drop, ld_in, load;
   always_comb begin
      stride_sext = {{(vaddr_width_p-stride_width_p){bus.stride[stride_width_p-1]}}, bus.stride};
      trig        = bus.stride_v && (bus.stride != '0);
      same_pc     = bus.pc == pc_r;
      blk         = cand_r[vaddr_width_p-1:block_offset_width_p];
      page_cross  = cand_r[vaddr_width_p-1:page_offset_width_p] != base_pg_r;
      dup         = last_blk_v_r && (blk == last_blk_r);
      pf_v        = (state_r == e_issue) && !page_cross && !dup;
      accept      = pf_v && bus.pf_ready;
      restart_ok  = !pf_v || bus.pf_ready;
      restart     = (state_r == e_issue) && restart_ok && ((trig && same_pc) || skid_v_r);
      to_skid     = (state_r == e_issue) && !restart_ok && trig && same_pc && !skid_v_r;
      drop        = (state_r == e_issue) && trig && (!same_pc || (!restart_ok && skid_v_r));
      degree      = confirmed_r ? rem_w'(degree_p) : rem_w'(degree_unconfirmed_p);
      // a fresh same-PC trigger supersedes any held skid entry
      ld_in       = (state_r == e_idle) || (trig && same_pc);
      ld_base     = ld_in ? bus.base_addr : skid_base_r;
      ld_stride   = ld_in ? stride_sext : skid_stride_r;
      ld_rem      = ld_in ? degree : skid_rem_r;
      load        = ((state_r == e_idle) && trig) || restart;
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r       <= e_idle;
         confirmed_r   <= 1'b0;
         last_blk_v_r  <= 1'b0;
         last_blk_r    <= '0;
         skid_v_r      <= 1'b0;
         skid_base_r   <= '0;
         skid_stride_r <= '0;
         skid_rem_r    <= '0;
         drop_cnt_r    <= '0;
         pc_r          <= '0;
         base_pg_r     <= '0;
         stride_r      <= '0;
         cand_r        <= '0;
         remaining_r   <= '0;
      end else begin
         confirmed_r <= !bus.start_discovery && (bus.confirm_discovery || confirmed_r);
         if (drop && drop_cnt_r != 8'hFF) drop_cnt_r <= drop_cnt_r + 8'd1;
         if (accept) begin
            last_blk_r   <= blk;
            last_blk_v_r <= 1'b1;
         end
         skid_v_r <= to_skid || (skid_v_r && !restart);
         if (to_skid) begin
            skid_base_r   <= bus.base_addr;
            skid_stride_r <= stride_sext;
            skid_rem_r    <= degree;
         end
         if (load) begin
            state_r     <= e_issue;
            if (ld_in) pc_r <= bus.pc;
            base_pg_r   <= ld_base[vaddr_width_p-1:page_offset_width_p];
            stride_r    <= ld_stride;
            remaining_r <= ld_rem;
            cand_r      <= ld_base + ld_stride;
         end else if (state_r == e_issue) begin
            if (page_cross) state_r <= e_idle;
            else if (dup) cand_r <= cand_r + stride_r;
            else if (accept) begin
               cand_r      <= cand_r + stride_r;
               remaining_r <= remaining_r - rem_w'(1);
               if (remaining_r == rem_w'(1)) state_r <= e_idle;
            end
         end
      end
   end
   assign bus.pf_v     = pf_v;
   assign bus.pf_addr  = pf_v ? {blk, {block_offset_width_p{1'b0}}} : '0;
   assign bus.busy     = state_r == e_issue;
   assign bus.drop_cnt = drop_cnt_r;
endmodule
